// File: rtl/r_forward_arbiter.sv
// Round-robin arbiter sharing one registered AR forward stage between NUM_SRC
// requesters, with a cap on outstanding reads retired by RDONE pulses.
module r_forward_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DW        = 77,
  parameter int SW        = $clog2(NUM_SRC),
  parameter int MAX_OUTST = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NUM_SRC*DW-1:0] IN_DATA,
  input  logic [NUM_SRC-1:0]    IN_VALID,
  output logic [NUM_SRC-1:0]    IN_READY,
  output logic [DW-1:0]         OUT_DATA,
  output logic [SW-1:0]         OUT_SRC,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  input  logic                  RDONE,
  output logic [7:0]            OUTST_CNT
);

  localparam int NP = 2 ** SW;

  logic [SW-1:0]  pri;
  logic [SW-1:0]  win;
  logic [SW-1:0]  nxt_pri;
  logic [SW:0]    pos;
  logic [NP-1:0]  vld_pad;
  logic [NP-1:0]  rdy_pad;
  logic [DW-1:0]  words [NP];
  logic           found;
  logic           load_en;
  logic           accept;

  // Padded views keep SW-bit indexing in range when NUM_SRC is not 2**SW
  always_comb begin
    vld_pad = NP'(IN_VALID);
    for (int i = 0; i < NP; i++) begin
      words[i] = '0;
      if (i < NUM_SRC) words[i] = IN_DATA[i*DW +: DW];
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    pos   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pos = {1'b0, pri} + (SW+1)'(k);
      if (pos >= (SW+1)'(NUM_SRC)) pos = pos - (SW+1)'(NUM_SRC);
      if (!found && vld_pad[pos[SW-1:0]]) begin
        found = 1'b1;
        win   = pos[SW-1:0];
      end
    end
  end

  assign load_en = !RESET && (!OUT_VALID || OUT_READY)
                && (OUTST_CNT < 8'(MAX_OUTST));
  assign accept  = load_en && found;
  assign nxt_pri = (win == SW'(NUM_SRC-1)) ? '0 : win + 1'b1;

  always_comb begin
    rdy_pad      = '0;
    rdy_pad[win] = accept;
    IN_READY     = rdy_pad[NUM_SRC-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_SRC   <= '0;
      OUTST_CNT <= '0;
      pri       <= '0;
    end else begin
      if (accept) begin
        OUT_DATA  <= words[win];
        OUT_SRC   <= win;
        OUT_VALID <= 1'b1;
        pri       <= nxt_pri;
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
      // Accept and completion in one cycle cancel; idle RDONE saturates at 0
      if (accept && !RDONE) begin
        OUTST_CNT <= OUTST_CNT + 8'd1;
      end else if (!accept && RDONE && OUTST_CNT != 8'd0) begin
        OUTST_CNT <= OUTST_CNT - 8'd1;
      end
    end
  end

endmodule

// File: doc/r_forward_arbiter.md
# r_forward_arbiter

Round-robin arbiter that shares one downstream read-address forward path between `NUM_SRC` requesters. Each requester presents an already-packed 77-bit AR word with a VALID/READY handshake. The block grants one requester per cycle and registers the winner into a single output stage, tagging it with the source index so the R return path can route responses. It also enforces a cap on outstanding read transactions using a completion pulse from the R return path.

## Interface
Parameters:
- `NUM_SRC`, 4: number of requesters (2..16).
- `DW`, 77: width of the packed AR word: {ID[7:0], ADDR[35:0], LEN[7:0], SIZE[2:0], BURST[1:0], LOCK, CACHE[3:0], PROT[2:0], QOS[3:0], REGION[3:0], USER[3:0]}.
- `SW`, $clog2(NUM_SRC): source-index width.
- `MAX_OUTST`, 16: maximum accepted-but-uncompleted transactions (1..255).

Ports:
- `CLK`  in  1  single clock; all logic rising-edge.
- `RESET`  in  1  synchronous, active-high reset.
- `IN_DATA`  in  NUM_SRC*DW  packed AR words; source i occupies bits [i*DW +: DW].
- `IN_VALID`  in  NUM_SRC  per-source request valid.
- `IN_READY`  out  NUM_SRC  per-source accept; at most one bit high.
- `OUT_DATA`  out  DW  registered AR word of the winner.
- `OUT_SRC`  out  SW  registered index of the winning source.
- `OUT_VALID`  out  1  output stage full.
- `OUT_READY`  in  1  downstream accept.
- `RDONE`  in  1  one-cycle pulse per completed read transaction (RLAST handshake on the return path).
- `OUTST_CNT`  out  8  current outstanding count.

## Operation
- Output stage holds one entry: `OUT_VALID`, `OUT_DATA`, `OUT_SRC`.
- `load_en` = !RESET && (!OUT_VALID || OUT_READY) && (OUTST_CNT < MAX_OUTST).
- Priority pointer `pri` (SW bits) selects the search start. The winner `g` is the first i with IN_VALID[i], scanning pri, pri+1, … and wrapping modulo NUM_SRC. If no input is valid, there is no winner.
- `IN_READY[g]` = load_en && winner exists. Grant and accept happen in the same cycle, so no grant locking is needed. A source's VALID may become visible to arbitration at any cycle.
- On accept (IN_VALID[g] && IN_READY[g]):
  - OUT_DATA <= IN_DATA[g].
  - OUT_SRC <= g.
  - OUT_VALID <= 1.
  - pri <= (g+1) mod NUM_SRC.
- On downstream handshake with no new accept: OUT_VALID <= 0. OUT_DATA and OUT_SRC keep their previous values.
- While OUT_VALID && !OUT_READY, OUT_DATA and OUT_SRC stay stable.
- Outstanding counter:
  - +1 on accept.
  - −1 on RDONE.
  - Accept and RDONE in the same cycle: unchanged.
  - RDONE with OUTST_CNT==0 and no accept: ignored; the counter saturates at 0.
- Limit check uses the registered count. A same-cycle RDONE does not bypass it: at OUTST_CNT==MAX_OUTST, an RDONE in cycle t permits an accept in cycle t+1 at the earliest.
- When `pri` is not a legal index (NUM_SRC not a power of 2), it never takes such a value because the update is modulo NUM_SRC.

## Timing
- Reset values, 1 cycle after RESET is sampled high: OUT_VALID=0, OUT_DATA=0, OUT_SRC=0, OUTST_CNT=0, pri=0.
- IN_READY is forced to 0 while RESET is high.
- Reset asserted mid-transaction drops the output-stage entry and clears the count. Upstream re-presents after reset.
- Latency: input accept in cycle t gives OUT_VALID in cycle t+1.
- Throughput: one transaction per cycle while OUT_READY=1 and under the limit. This gives full-rate back-to-back operation because a consume and a load may occur in the same cycle.
- IN_READY is combinational from IN_VALID, OUT_VALID, OUT_READY and OUTST_CNT. No combinational path exists from IN_DATA to any output.
- Backpressure: OUT_READY=0 with OUT_VALID=1 deasserts all IN_READY in the same cycle.

## Test plan
- Reset: hold RESET 3 cycles with all IN_VALID=1 -> IN_READY=0 throughout; after release OUT_VALID=0, OUTST_CNT=0, and the first grant goes to source 0.
- Round robin: NUM_SRC=4, all IN_VALID held 1, OUT_READY=1, RDONE pulsing every cycle -> OUT_SRC sequence is 0,1,2,3,0,1 on consecutive cycles, and OUT_DATA equals each source's word (e.g. source i drives ID=8'h10+i).
- Sparse requesters: only sources 1 and 3 valid, pri=0 -> grants 1,3,1,3; then source 2 alone -> grant 2 and pri becomes 3.
- Backpressure: OUT_READY=0 for 5 cycles after an accept of ADDR=36'h0_1234_5678 -> OUT_DATA stable, all IN_READY=0; OUT_READY=1 -> handshake and a new accept in the same cycle.
- Outstanding limit: MAX_OUTST=2, no RDONE -> two accepts, then IN_READY=0 with OUTST_CNT=2. One RDONE pulse in cycle t -> count 1 at t+1 and an accept at t+1 (not at t).
- Counter edges: RDONE together with an accept -> count unchanged. RDONE at count 0 -> count stays 0. RESET asserted with count 5 and OUT_VALID=1 -> both cleared next cycle.
